// File: rtl/sub_bytes_engine_pkg.sv
// Shared AES definitions (AESDefinitions): byte/state types and the forward/inverse S-box tables.
// Also carries the sub_bytes_engine lane default and FSM encoding.
package AESDefinitions;

  localparam int AES_STATE_SIZE = 16;
  localparam int SUB_BYTES_LANES_DEFAULT = 4;

  typedef logic [7:0] byte_t;
  typedef byte_t [AES_STATE_SIZE-1:0] state_t;

  typedef enum logic [1:0] {
    SBE_IDLE = 2'd0,
    SBE_RUN  = 2'd1,
    SBE_DONE = 2'd2
  } sbe_state_e;

  // Indexed as {row, col} = {byte[7:4], byte[3:0]}.
  localparam byte_t sbox [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam byte_t invSbox [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/sub_bytes_engine_sbox_lane.sv
// sbox_lane: one combinational byte substitution (forward, or inverse when INV_SBOX_EN is defined).
// Without INV_SBOX_EN the mode input is ignored and no inverse table is referenced.
module sbox_lane
  import AESDefinitions::*;
(
  input  byte_t in_byte,
  input  logic  inverse,
  output byte_t out_byte
);

  logic [3:0] row;
  logic [3:0] col;
  byte_t      fwd;

  assign row = in_byte[7:4];
  assign col = in_byte[3:0];
  assign fwd = sbox[{row, col}];

`ifdef INV_SBOX_EN
  assign out_byte = inverse ? invSbox[{row, col}] : fwd;
`else
  logic unused_inverse;
  assign unused_inverse = inverse;
  assign out_byte       = fwd;
`endif

endmodule

// File: rtl/sub_bytes_engine.sv
// sub_bytes_engine: AES (Inv)SubBytes over a 16-byte state, LANES bytes per clock, valid/ready on both sides.
// Optional macro INV_SBOX_EN adds the inverse S-box and the in_inverse path.
module sub_bytes_engine
  import AESDefinitions::*;
#(
  parameter int LANES = SUB_BYTES_LANES_DEFAULT
) (
  input  logic   clock,
  input  logic   reset_n,
  input  logic   in_valid,
  output logic   in_ready,
  input  state_t in_state,
  input  logic   in_inverse,
  output logic   out_valid,
  input  logic   out_ready,
  output state_t out_state,
  output logic   out_inverse,
  output logic   busy
);

  localparam int N     = AES_STATE_SIZE / LANES;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_engine: illegal LANES=%0d (allowed 1,2,4,8,16)", LANES);
  end

  sbe_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  state_t            work_q, work_d;
  logic              mode;
  logic              accept;

  byte_t      [LANES-1:0] lane_in;
  byte_t      [LANES-1:0] lane_out;
  logic [LANES-1:0] [3:0] lane_idx;

`ifdef INV_SBOX_EN
  logic inv_q, inv_d;
  assign mode        = inv_q;
  assign out_inverse = inv_q;
`else
  logic unused_in_inverse;
  assign unused_in_inverse = in_inverse;
  assign mode              = 1'b0;
  assign out_inverse       = 1'b0;
`endif

  // Lane i works on byte cnt*LANES + i of the working state this cycle.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign lane_idx[i] = 4'(int'(cnt_q) * LANES + i);
    assign lane_in[i]  = work_q[lane_idx[i]];
    sbox_lane u_lane (
      .in_byte  (lane_in[i]),
      .inverse  (mode),
      .out_byte (lane_out[i])
    );
  end

  assign in_ready  = (state_q == SBE_IDLE) || ((state_q == SBE_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == SBE_DONE);
  assign busy      = (state_q == SBE_RUN);
  assign out_state = work_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
`ifdef INV_SBOX_EN
    inv_d   = inv_q;
`endif
    if (accept) begin
      state_d = SBE_RUN;
      cnt_d   = '0;
      work_d  = in_state;
`ifdef INV_SBOX_EN
      inv_d   = in_inverse;
`endif
    end else begin
      case (state_q)
        SBE_RUN: begin
          for (int i = 0; i < LANES; i++) work_d[lane_idx[i]] = lane_out[i];
          if (cnt_q == CNT_W'(N - 1)) begin
            cnt_d   = '0;
            state_d = SBE_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        // Consumed with nothing new waiting: go idle; a waiting state is caught by accept.
        SBE_DONE: if (out_ready) state_d = SBE_IDLE;
        default:  state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SBE_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
`ifdef INV_SBOX_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
`ifdef INV_SBOX_EN
      inv_q   <= inv_d;
`endif
    end
  end

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Bench for sub_bytes_engine: LANES=1/4/16 instances checked against a GF(2^8)-derived S-box model.
module tb_sub_bytes_engine;
  import AESDefinitions::*;

`ifdef INV_SBOX_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic   clock = 1'b0;
  logic   reset_n = 1'b0;
  logic   iv[3], ii[3], ordy[3];
  logic   irdy[3], ov[3], oinv[3], bsy[3];
  state_t ist[3], ost[3];
  int     NL[3] = '{16, 4, 1};

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] fwd_tab[256];
  logic [7:0] inv_tab[256];

  always #5 clock = ~clock;

  sub_bytes_engine #(.LANES(1)) u_l1 (
    .clock(clock), .reset_n(reset_n), .in_valid(iv[0]), .in_ready(irdy[0]), .in_state(ist[0]),
    .in_inverse(ii[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_state(ost[0]),
    .out_inverse(oinv[0]), .busy(bsy[0]));
  sub_bytes_engine #(.LANES(4)) u_l4 (
    .clock(clock), .reset_n(reset_n), .in_valid(iv[1]), .in_ready(irdy[1]), .in_state(ist[1]),
    .in_inverse(ii[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_state(ost[1]),
    .out_inverse(oinv[1]), .busy(bsy[1]));
  sub_bytes_engine #(.LANES(16)) u_l16 (
    .clock(clock), .reset_n(reset_n), .in_valid(iv[2]), .in_ready(irdy[2]), .in_state(ist[2]),
    .in_inverse(ii[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_state(ost[2]),
    .out_inverse(oinv[2]), .busy(bsy[2]));

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int k);
    return (b << k) | (b >> (8 - k));
  endfunction

  // S-box = affine transform of the multiplicative inverse in GF(2^8).
  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] s;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      fwd_tab[x] = s;
      inv_tab[s] = 8'(x);
    end
  endtask

  function automatic state_t ref_sub(input state_t s, input logic md);
    state_t r;
    for (int i = 0; i < 16; i++) r[i] = (INV_EN && md) ? inv_tab[s[i]] : fwd_tab[s[i]];
    return r;
  endfunction

  function automatic state_t rnd_state();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One full transaction on instance d: wait ready, accept, measure latency, check result.
  task automatic xact(input int d, input state_t st, input logic md, input string tag);
    int cyc = 0;
    while (!irdy[d] && cyc < 50) begin tick(); cyc++; end
    chk({tag, "_rdy"}, 128'(irdy[d]), 128'(1));
    iv[d] = 1'b1; ist[d] = st; ii[d] = md;
    tick();
    iv[d] = 1'b0;
    cyc = 0;
    while (!ov[d] && cyc < 100) begin tick(); cyc++; end
    chk({tag, "_lat"}, 128'(cyc), 128'(NL[d]));
    chk({tag, "_state"}, ost[d], ref_sub(st, md));
    chk({tag, "_mode"}, 128'(oinv[d]), 128'(INV_EN && md));
  endtask

  initial begin
    state_t st, st2;
    logic   md, md2, seen;
    int     cyc, nres, last_t;
    state_t expq[$];

    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; ii[d] = 1'b0; ordy[d] = 1'b1; ist[d] = '0;
    end
    build_tables();
    #12;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_rdy%0d", d), 128'(irdy[d]), 128'(1));
      chk($sformatf("rst_ov%0d", d), 128'(ov[d]), 128'(0));
      chk($sformatf("rst_busy%0d", d), 128'(bsy[d]), 128'(0));
      chk($sformatf("rst_oinv%0d", d), 128'(oinv[d]), 128'(0));
      chk($sformatf("rst_ost%0d", d), ost[d], 128'(0));
    end
    @(posedge clock); #1 reset_n = 1'b1;

    // Directed known-answer vectors.
    xact(1, '0, 1'b0, "l4_zero");
    chk("l4_zero_kat", ost[1], {16{8'h63}});
    xact(0, 128'h0f0e0d0c0b0a09080706050403020100, 1'b0, "l1_seq");
    chk("l1_seq_kat", ost[0], 128'h76abd7fe2b670130c56f6bf27b777c63);
    xact(1, {16{8'h53}}, 1'b0, "l4_53");
    chk("l4_53_kat", ost[1], {16{8'hed}});
    // in_inverse must be ignored when the inverse path is not built.
    xact(1, {16{8'h63}}, 1'b1, "l4_63i");
    chk("l4_63i_kat", ost[1], INV_EN ? 128'(0) : {16{8'hfb}});
`ifdef INV_SBOX_EN
    xact(2, {16{8'hed}}, 1'b1, "l16_edi");
    chk("l16_edi_kat", ost[2], {16{8'h53}});
    chk("l16_edi_oinv", 128'(oinv[2]), 128'(1));
`endif

    // Random traffic on every width.
    for (int d = 0; d < 3; d++)
      for (int k = 0; k < 4; k++)
        xact(d, rnd_state(), 1'($urandom_range(0, 1)), $sformatf("rnd%0d_%0d", d, k));

    // Downstream stall: output held, input blocked, pending state not captured.
    ordy[1] = 1'b0;
    st = rnd_state(); md = 1'($urandom_range(0, 1));
    st2 = rnd_state(); md2 = ~md;
    xact(1, st, md, "stall");
    iv[1] = 1'b1; ist[1] = st2; ii[1] = md2;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("stall_ost%0d", k), ost[1], ref_sub(st, md));
      chk($sformatf("stall_oinv%0d", k), 128'(oinv[1]), 128'(INV_EN && md));
      chk($sformatf("stall_rdy%0d", k), 128'(irdy[1]), 128'(0));
      chk($sformatf("stall_ov%0d", k), 128'(ov[1]), 128'(1));
    end
    ordy[1] = 1'b1;
    tick();
    iv[1] = 1'b0;
    cyc = 0;
    while (!ov[1] && cyc < 100) begin tick(); cyc++; end
    chk("stall_next_lat", 128'(cyc), 128'(4));
    chk("stall_next_state", ost[1], ref_sub(st2, md2));

    // Reset mid-RUN at cnt = 2 on the LANES=1 instance.
    tick();
    cyc = 0;
    while (!irdy[0] && cyc < 50) begin tick(); cyc++; end
    iv[0] = 1'b1; ist[0] = rnd_state(); ii[0] = 1'b0;
    tick();
    iv[0] = 1'b0;
    tick(); tick();
    chk("mid_busy", 128'(bsy[0]), 128'(1));
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ov", 128'(ov[0]), 128'(0));
    chk("mid_rst_rdy", 128'(irdy[0]), 128'(1));
    chk("mid_rst_busy", 128'(bsy[0]), 128'(0));
    chk("mid_rst_ost", ost[0], 128'(0));
    tick();
    reset_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (ov[0]) seen = 1'b1;
    end
    chk("mid_rst_noemit", 128'(seen), 128'(0));

    // Back-to-back on LANES=16: one result every 2 cycles, in order.
    nres = 0; last_t = -1;
    st = rnd_state(); md = 1'($urandom_range(0, 1));
    iv[2] = 1'b1; ist[2] = st; ii[2] = md;
    for (int t = 0; t < 40 && nres < 6; t++) begin
      logic acc;
      acc = iv[2] && irdy[2];
      tick();
      if (acc) begin
        expq.push_back(ref_sub(ist[2], ii[2]));
        ist[2] = rnd_state(); ii[2] = 1'($urandom_range(0, 1));
      end
      if (ov[2]) begin
        if (expq.size() > 0) chk($sformatf("b2b_state%0d", nres), ost[2], expq.pop_front());
        else chk($sformatf("b2b_spurious%0d", nres), 128'(1), 128'(0));
        if (last_t >= 0) chk($sformatf("b2b_gap%0d", nres), 128'(t - last_t), 128'(2));
        last_t = t;
        nres++;
      end
    end
    iv[2] = 1'b0;
    chk("b2b_count", 128'(nres), 128'(6));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
